// File: rtl/bv_responder.sv
`timescale 1ns/1ps
// Bill-validator slave responder.
// Parses host frames (02 03 06 CMD CRCL CRCH), tracks the validator status,
// and answers POLL commands after a fixed delay through a handshaked UART
// transmitter.
module bv_responder #(
   parameter int TIMEOUT_CYCLES = 10000,
   parameter int RESP_DELAY     = 2000
) (
   input  logic       CLK_10MHZ,
   input  logic       RST,
   input  logic [7:0] rx_data,
   input  logic       rx_ready,
   output logic [7:0] tx_data,
   output logic       tx_start,
   input  logic       tx_busy,
   input  logic       enable,
   input  logic       bill_insert,
   input  logic [1:0] bill_code,
   output logic [7:0] bv_state,
   output logic [7:0] crc_err_cnt
);

   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam int DW = (RESP_DELAY > 1) ? $clog2(RESP_DELAY + 1) : 1;

   localparam logic [7:0] ST_POWER_UP  = 8'h10;
   localparam logic [7:0] ST_INIT      = 8'h13;
   localparam logic [7:0] ST_DISABLED  = 8'h19;
   localparam logic [7:0] ST_IDLE      = 8'h14;
   localparam logic [7:0] ST_ACCEPTING = 8'h15;
   localparam logic [7:0] ST_STACKING  = 8'h17;

   localparam logic [7:0] CMD_RESET = 8'h30;
   localparam logic [7:0] CMD_POLL  = 8'h33;
   localparam logic [7:0] CMD_ACK   = 8'h00;

   typedef enum logic [2:0] {P_HUNT, P_SYNC1, P_LEN, P_CMD, P_CRC0, P_CRC1} parse_e;
   typedef enum logic [2:0] {T_IDLE, T_DELAY, T_LOAD, T_WAIT_HI, T_WAIT_LO} tx_e;
   typedef enum logic [1:0] {EV_NONE, EV_BILL, EV_REJECT} evt_e;

   // CRC-16, reflected polynomial 0x8408, one byte folded in LSB first.
   function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
      logic [15:0] r;
      r = c ^ {8'h00, b};
      for (int i = 0; i < 8; i++) begin
         r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
      end
      return r;
   endfunction

   parse_e        parse_q, parse_d;
   logic [15:0]   crc_q, crc_d;
   logic [7:0]    cmd_q, cmd_d;
   logic [7:0]    crcl_q, crcl_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          rx_ready_q, rx_ready_d;
   logic [7:0]    state_q, state_d;
   logic [7:0]    err_q, err_d;
   evt_e          evt_q, evt_d;
   logic [7:0]    bc_q, bc_d;
   logic [7:0]    resp_q [5];
   logic [7:0]    resp_d [5];
   logic [2:0]    resp_len_q, resp_len_d;

   tx_e           tx_st_q, tx_st_d;
   logic [DW-1:0] dly_q, dly_d;
   logic [2:0]    idx_q, idx_d;
   logic [15:0]   tcrc_q, tcrc_d;
   logic [7:0]    tx_data_q, tx_data_d;
   logic          tx_start_q, tx_start_d;

   logic          rx_stb;
   logic          resp_go;
   logic [7:0]    cur_byte;

   // Host bytes count only on a rising rx_ready while the link is ours to listen on.
   assign rx_stb = rx_ready & ~rx_ready_q & (tx_st_q == T_IDLE);

   assign tx_data     = tx_data_q;
   assign tx_start    = tx_start_q;
   assign bv_state    = state_q;
   assign crc_err_cnt = err_q;

   // Frame parser, inter-byte timeout, command execution and bill events.
   always_comb begin
      // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
      parse_d    = parse_q;
      crc_d      = crc_q;
      cmd_d      = cmd_q;
      crcl_d     = crcl_q;
      tmo_d      = tmo_q;
      rx_ready_d = rx_ready;
      state_d    = state_q;
      err_d      = err_q;
      evt_d      = evt_q;
      bc_d       = bc_q;
      resp_d     = resp_q;
      resp_len_d = resp_len_q;
      resp_go    = 1'b0;

      if (parse_q != P_HUNT) begin
         if (rx_stb) begin
            tmo_d = '0;
         end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            tmo_d   = '0;
            parse_d = P_HUNT;
         end else begin
            tmo_d = tmo_q + TW'(1);
         end
      end

      if (bill_insert && state_q == ST_IDLE && evt_q == EV_NONE) begin
         if (bill_code != 2'd0) begin
            state_d = ST_ACCEPTING;
            bc_d    = {6'd0, bill_code} + 8'd1;
         end else begin
            evt_d = EV_REJECT;
         end
      end

      if (rx_stb) begin
         unique case (parse_q)
            P_HUNT: begin
               if (rx_data == 8'h02) begin
                  crc_d   = crc_upd(16'h0000, rx_data);
                  tmo_d   = '0;
                  parse_d = P_SYNC1;
               end
            end
            P_SYNC1: begin
               crc_d   = crc_upd(crc_q, rx_data);
               parse_d = (rx_data == 8'h03) ? P_LEN : P_HUNT;
            end
            P_LEN: begin
               crc_d   = crc_upd(crc_q, rx_data);
               parse_d = (rx_data == 8'h06) ? P_CMD : P_HUNT;
            end
            P_CMD: begin
               crc_d   = crc_upd(crc_q, rx_data);
               cmd_d   = rx_data;
               parse_d = P_CRC0;
            end
            P_CRC0: begin
               crcl_d  = rx_data;
               parse_d = P_CRC1;
            end
            P_CRC1: begin
               parse_d = P_HUNT;
               if ({rx_data, crcl_q} != crc_q) begin
                  if (err_q != 8'hFF) err_d = err_q + 8'd1;
               end else begin
                  unique case (cmd_q)
                     CMD_RESET: begin
                        state_d = ST_INIT;
                        evt_d   = EV_NONE;
                     end
                     CMD_ACK: evt_d = EV_NONE;
                     CMD_POLL: begin
                        resp_go   = 1'b1;
                        resp_d[0] = 8'h02;
                        resp_d[1] = 8'h03;
                        unique case (evt_q)
                           EV_BILL: begin
                              resp_d[2] = 8'h04; resp_d[3] = 8'h81; resp_d[4] = bc_q;
                              resp_len_d = 3'd5;
                           end
                           EV_REJECT: begin
                              resp_d[2] = 8'h04; resp_d[3] = 8'h1C; resp_d[4] = 8'h60;
                              resp_len_d = 3'd5;
                           end
                           default: begin
                              resp_d[2] = 8'h03; resp_d[3] = state_q; resp_d[4] = 8'h00;
                              resp_len_d = 3'd4;
                           end
                        endcase
                        unique case (state_q)
                           ST_INIT:      state_d = ST_DISABLED;
                           ST_DISABLED:  if (enable)  state_d = ST_IDLE;
                           ST_IDLE:      if (!enable) state_d = ST_DISABLED;
                           ST_ACCEPTING: state_d = ST_STACKING;
                           ST_STACKING: begin
                              state_d = ST_IDLE;
                              evt_d   = EV_BILL;
                           end
                           default: ;
                        endcase
                     end
                     default: ;
                  endcase
               end
            end
            default: parse_d = P_HUNT;
         endcase
      end
   end

   // Response engine: delay, then one byte per tx_busy rise/fall cycle, CRC appended.
   always_comb begin
      tx_st_q_hold: begin
         tx_st_d    = tx_st_q;
         dly_d      = dly_q;
         idx_d      = idx_q;
         tcrc_d     = tcrc_q;
         tx_data_d  = tx_data_q;
         tx_start_d = tx_start_q;
      end

      if (idx_q < resp_len_q) begin
         unique case (idx_q)
            3'd0:    cur_byte = resp_q[0];
            3'd1:    cur_byte = resp_q[1];
            3'd2:    cur_byte = resp_q[2];
            3'd3:    cur_byte = resp_q[3];
            default: cur_byte = resp_q[4];
         endcase
      end else if (idx_q == resp_len_q) begin
         cur_byte = tcrc_q[7:0];
      end else begin
         cur_byte = tcrc_q[15:8];
      end

      unique case (tx_st_q)
         T_IDLE: begin
            if (resp_go) begin
               tx_st_d = T_DELAY;
               dly_d   = '0;
               idx_d   = 3'd0;
               tcrc_d  = 16'h0000;
            end
         end
         T_DELAY: begin
            if (dly_q == DW'(RESP_DELAY - 1)) tx_st_d = T_LOAD;
            else                              dly_d   = dly_q + DW'(1);
         end
         T_LOAD: begin
            if (!tx_busy) begin
               tx_data_d  = cur_byte;
               tx_start_d = 1'b1;
               if (idx_q < resp_len_q) tcrc_d = crc_upd(tcrc_q, cur_byte);
               tx_st_d    = T_WAIT_HI;
            end
         end
         T_WAIT_HI: begin
            if (tx_busy) begin
               tx_start_d = 1'b0;
               tx_st_d    = T_WAIT_LO;
            end
         end
         T_WAIT_LO: begin
            if (!tx_busy) begin
               if (idx_q == resp_len_q + 3'd1) begin
                  tx_st_d = T_IDLE;
               end else begin
                  idx_d   = idx_q + 3'd1;
                  tx_st_d = T_LOAD;
               end
            end
         end
         default: tx_st_d = T_IDLE;
      endcase
   end

   // Control and status registers with synchronous reset.
   always_ff @(posedge CLK_10MHZ) begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      if (RST) begin
         parse_q    <= P_HUNT;
         crc_q      <= 16'h0000;
         cmd_q      <= 8'h00;
         crcl_q     <= 8'h00;
         tmo_q      <= '0;
         rx_ready_q <= 1'b0;
         state_q    <= ST_POWER_UP;
         err_q      <= 8'h00;
         evt_q      <= EV_NONE;
         bc_q       <= 8'h00;
         resp_len_q <= 3'd4;
         tx_st_q    <= T_IDLE;
         dly_q      <= '0;
         idx_q      <= 3'd0;
         tcrc_q     <= 16'h0000;
         tx_data_q  <= 8'h00;
         tx_start_q <= 1'b0;
      end else begin
         parse_q    <= parse_d;
         crc_q      <= crc_d;
         cmd_q      <= cmd_d;
         crcl_q     <= crcl_d;
         tmo_q      <= tmo_d;
         rx_ready_q <= rx_ready_d;
         state_q    <= state_d;
         err_q      <= err_d;
         evt_q      <= evt_d;
         bc_q       <= bc_d;
         resp_len_q <= resp_len_d;
         tx_st_q    <= tx_st_d;
         dly_q      <= dly_d;
         idx_q      <= idx_d;
         tcrc_q     <= tcrc_d;
         tx_data_q  <= tx_data_d;
         tx_start_q <= tx_start_d;
      end
   end

   // Response payload storage.
   always_ff @(posedge CLK_10MHZ) begin
      // NOTE: payload bytes are pure data, always written before they are read, so they carry no reset.
      resp_q <= resp_d;
   end

endmodule

// File: doc/bv_responder.md
BV_RESPONDER -- requirements
Module: bv_responder

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 10000: idle cycles allowed between host bytes inside one frame (1 ms at 10 MHz).
REQ-002 Parameter RESP_DELAY, default 2000: cycles from the last valid host byte to the first response byte.
REQ-003 CLK_10MHZ  input  1  sole clock; all logic SHALL be clocked on its rising edge.
REQ-004 RST  input  1  reset, synchronous and active-high.
REQ-005 rx_data  input  8  received UART byte.
REQ-006 rx_ready  input  1  receiver data-ready level; a byte is consumed on the rising edge of rx_ready only.
REQ-007 tx_data  output  8  byte presented to the UART transmitter.
REQ-008 tx_start  output  1  transmit request level.
REQ-009 tx_busy  input  1  transmitter busy flag.
REQ-010 enable  input  1  host-side bill acceptance enable.
REQ-011 bill_insert  input  1  single-cycle pulse: a bill has been inserted.
REQ-012 bill_code  input  2  denomination, sampled with bill_insert: 1→0x02, 2→0x03, 3→0x04, 0→reject.
REQ-013 bv_state  output  8  current status code.
REQ-014 crc_err_cnt  output  8  count of frames discarded because of a CRC failure; saturates at 0xFF.

Function
REQ-015 Host frame format SHALL be 02 03 06 CMD CRCL CRCH. The CRC SHALL be CRC-16 with polynomial 0x8408, LSB-first, init 0x0000, computed over bytes 0–3, with the low byte sent first.
REQ-016 The parser SHALL use states HUNT, SYNC1, LEN, CMD, CRC0, CRC1. Any mismatch on byte 0–2 SHALL return the parser to HUNT. A byte of 0x02 received in HUNT SHALL restart the frame.
REQ-017 If TIMEOUT_CYCLES elapse inside a frame with no new byte, the parser SHALL return to HUNT without counting an error.
REQ-018 A CRC mismatch SHALL discard the frame and increment crc_err_cnt.
REQ-019 Status codes SHALL be POWER_UP 0x10, INIT 0x13, DISABLED 0x19, IDLE 0x14, ACCEPTING 0x15, STACKING 0x17.
REQ-020 A valid RESET command (0x30) SHALL set bv_state to INIT, clear any pending event, and produce no response.
REQ-021 A valid POLL command (0x33) SHALL, after RESP_DELAY, transmit one of the following:
- Pending bill event: the 7-byte frame 02 03 04 81 BC CRCL CRCH, where BC is the mapped bill code.
- Pending reject: the 7-byte frame 02 03 04 1C 60 CRCL CRCH.
- Otherwise: the 6-byte frame 02 03 03 ST CRCL CRCH, where ST is bv_state.
REQ-022 State transitions on POLL, applied after the response is queued:
- INIT→DISABLED.
- DISABLED→IDLE if enable=1.
- IDLE→DISABLED if enable=0.
- ACCEPTING→STACKING.
- STACKING→IDLE, with a bill event set pending.
REQ-023 A valid ACK command (0x00) SHALL clear the pending event and produce no response. If no ACK arrives, the pending event SHALL repeat on every POLL.
REQ-024 Any other command with a valid CRC SHALL be ignored.
REQ-025 bill_insert SHALL act only in IDLE with no event pending:
- bill_code≠0 moves the state to ACCEPTING and latches BC.
- bill_code=0 sets a reject pending and leaves the state in IDLE.
- In every other case bill_insert SHALL be ignored.
REQ-026 Transmit handshake:
- Load tx_data and assert tx_start only when tx_busy=0.
- Drop tx_start in the cycle after tx_busy is seen rising.
- Load the next byte only after tx_busy falls.
- The response CRC SHALL be computed over all preceding response bytes.
REQ-027 The link is half-duplex: bytes received while a response is delayed or transmitting SHALL be ignored.
REQ-028 A second valid frame SHALL never preempt a response that is in progress.

Reset
REQ-029 While RST=1 at a clock edge, the block SHALL set the following and hold them until RST falls:
- bv_state=0x10, crc_err_cnt=0, tx_start=0, tx_data=0x00.
- Parser in HUNT.
- No pending event, delay and timeout counters cleared.
REQ-030 An RST asserted mid-response SHALL abort the response; tx_start SHALL be 0 in the cycle after the RST edge and no further bytes SHALL be sent.

Verification
REQ-031 Directed scenarios the bench SHALL cover:
- Reset, then host sends 02 03 06 33 DA 81 → after RESP_DELAY, response 02 03 03 10 + CRC; bv_state stays 0x10.
- Host sends 02 03 06 30 41 B3, then POLL → response status 0x13; a second POLL → status 0x19; with enable=1, a third POLL → status 0x19 and bv_state becomes 0x14.
- In IDLE, bill_insert with bill_code=2, then POLL ×3 → statuses 0x15, 0x17, then frame 02 03 04 81 03 + CRC; without ACK the next POLL repeats the event; after 02 03 06 00 C2 82, POLL → status 0x14.
- POLL frame with its last byte corrupted to 0x80 → no response and crc_err_cnt=1; 256 further bad frames → crc_err_cnt=0xFF.
- Send 02 03 06, stall 10001 cycles, then send 33 DA 81 → no response and crc_err_cnt unchanged.
- Assert RST during the third response byte → tx_start=0 on the next cycle and bv_state=0x10.
